// File: rtl/mux_rr_arbiter_16.sv
// 16-way round-robin arbiter feeding a registered valid/ready output slot.
// One winner per transfer, with an idle bubble after each handshake.
module mux_rr_arbiter_16 #(
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           req_i,
    input  logic [16*WIDTH-1:0]   data_i,
    input  logic                  ready_i,
    output logic [WIDTH-1:0]      data_o,
    output logic                  valid_o,
    output logic [3:0]            sel_o,
    output logic [15:0]           grant_o,
    output logic [15:0]           ack_o
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         ptr_q, ptr_d;
    logic [3:0]         sel_q, sel_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [15:0]        grant_q, grant_d;
    logic               pick_found_s;
    logic [3:0]         pick_idx_s;

    // Returns {found, index} of the first set request at or after ptr, wrapping mod 16.
    function automatic logic [4:0] rr_pick(input logic [15:0] req, input logic [3:0] ptr);
        logic [4:0] res;
        logic [3:0] idx;
        res = 5'd0;
        for (int i = 15; i >= 0; i--) begin
            idx = ptr + 4'(i);
            if (req[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Winner search from the current priority pointer.
    always_comb begin
        {pick_found_s, pick_idx_s} = rr_pick(req_i, ptr_q);
    end

    // Next-state logic: latch a winner in IDLE, hold in SEND until the handshake.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        data_d  = data_q;
        grant_d = grant_q;
        case (state_q)
            IDLE: begin
                if (pick_found_s) begin
                    state_d = SEND;
                    sel_d   = pick_idx_s;
                    data_d  = data_i[pick_idx_s*WIDTH +: WIDTH];
                    grant_d = 16'd1 << pick_idx_s;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                if (ready_i) begin
                    state_d = IDLE;
                    ptr_d   = sel_q + 4'd1;
                    grant_d = 16'd0;
                end else begin
                    state_d = SEND;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 16'd0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 4'd0;
            sel_q   <= 4'd0;
            data_q  <= '0;
            grant_q <= 16'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            grant_q <= grant_d;
        end
    end

    // The ack pulse must coincide with the handshake cycle, so it is decoded
    // from registered state and the live ready_i rather than registered itself.
    always_comb begin
        if ((state_q == SEND) && ready_i) begin
            ack_o = grant_q;
        end else begin
            ack_o = 16'd0;
        end
    end

    assign valid_o = (state_q == SEND);
    assign sel_o   = sel_q;
    assign data_o  = data_q;
    assign grant_o = grant_q;

endmodule

// File: tb/tb_mux_rr_arbiter_16.sv
// Self-checking bench for mux_rr_arbiter_16: fixed vector table, directed
// corner sequences and random traffic against a transfer-level model.
module tb_mux_rr_arbiter_16;

    localparam int W = 4;

    logic            clk;
    logic            rst_n;
    logic [15:0]     req_i;
    logic [16*W-1:0] data_i;
    logic            ready_i;
    logic [W-1:0]    data_o;
    logic            valid_o;
    logic [3:0]      sel_o;
    logic [15:0]     grant_o;
    logic [15:0]     ack_o;

    int n_pass;
    int n_total;

    // Reference model: a pending transfer (who, what) and the priority pointer.
    bit         m_busy;
    int         m_ptr;
    int         m_sel;
    logic [3:0] m_data;

    mux_rr_arbiter_16 #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_i   (req_i),
        .data_i  (data_i),
        .ready_i (ready_i),
        .data_o  (data_o),
        .valid_o (valid_o),
        .sel_o   (sel_o),
        .grant_o (grant_o),
        .ack_o   (ack_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_ptr  = 0;
        m_sel  = 0;
        m_data = 4'h0;
    endtask

    // Called at the edge with the inputs that were sampled there.
    task automatic model_edge(input logic [15:0] req, input logic [63:0] data, input logic rdy);
        int k;
        if (!m_busy) begin
            for (int i = 0; i < 16; i++) begin
                k = (m_ptr + i) % 16;
                if (req[k]) begin
                    m_busy = 1'b1;
                    m_sel  = k;
                    m_data = data[k*4 +: 4];
                    break;
                end
            end
        end else if (rdy) begin
            m_ptr  = (m_sel + 1) % 16;
            m_busy = 1'b0;
        end
    endtask

    // Apply inputs (at negedge), compare outputs against the model, clock once.
    task automatic cyc(input logic [15:0] req, input logic [63:0] data, input logic rdy);
        logic [15:0] exp_grant;
        logic [15:0] exp_ack;
        req_i   = req;
        data_i  = data;
        ready_i = rdy;
        #1;
        exp_grant = m_busy ? (16'd1 << m_sel) : 16'd0;
        exp_ack   = (m_busy && rdy) ? (16'd1 << m_sel) : 16'd0;
        chk("valid", 64'(valid_o), 64'(m_busy));
        chk("sel",   64'(sel_o),   64'(m_sel));
        chk("data",  64'(data_o),  64'(m_data));
        chk("grant", 64'(grant_o), 64'(exp_grant));
        chk("ack",   64'(ack_o),   64'(exp_ack));
        @(posedge clk);
        model_edge(req, data, rdy);
        @(negedge clk);
    endtask

    task automatic do_reset();
        req_i   = 16'd0;
        data_i  = 64'd0;
        ready_i = 1'b0;
        rst_n   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [15:0] req;
        logic [63:0] data;
        logic        ready;
        logic        valid;
        logic [3:0]  sel;
        logic [3:0]  dat;
        logic [15:0] grant;
        logic [15:0] ack;
    } vec_t;

    vec_t tbl[6];
    logic [63:0] dvec;
    logic [15:0] rq;
    int seen[$];

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b1;
        req_i   = 16'd0;
        data_i  = 64'd0;
        ready_i = 1'b0;

        // Single request on slot 3 (data A), then slots 3 and 4 from ptr=4.
        dvec = 64'h0000_0000_000B_A000;
        tbl[0] = '{16'h0008, dvec, 1'b1, 1'b0, 4'd0, 4'h0, 16'h0000, 16'h0000};
        tbl[1] = '{16'h0000, dvec, 1'b1, 1'b1, 4'd3, 4'hA, 16'h0008, 16'h0008};
        tbl[2] = '{16'h0000, dvec, 1'b1, 1'b0, 4'd3, 4'hA, 16'h0000, 16'h0000};
        tbl[3] = '{16'h0018, dvec, 1'b0, 1'b0, 4'd3, 4'hA, 16'h0000, 16'h0000};
        tbl[4] = '{16'h0000, dvec, 1'b1, 1'b1, 4'd4, 4'hB, 16'h0010, 16'h0010};
        tbl[5] = '{16'h0000, dvec, 1'b0, 1'b0, 4'd4, 4'hB, 16'h0000, 16'h0000};

        @(negedge clk);
        do_reset();
        for (int i = 0; i < 6; i++) begin
            req_i   = tbl[i].req;
            data_i  = tbl[i].data;
            ready_i = tbl[i].ready;
            #1;
            chk($sformatf("tbl%0d.valid", i), 64'(valid_o), 64'(tbl[i].valid));
            chk($sformatf("tbl%0d.sel", i),   64'(sel_o),   64'(tbl[i].sel));
            chk($sformatf("tbl%0d.data", i),  64'(data_o),  64'(tbl[i].dat));
            chk($sformatf("tbl%0d.grant", i), 64'(grant_o), 64'(tbl[i].grant));
            chk($sformatf("tbl%0d.ack", i),   64'(ack_o),   64'(tbl[i].ack));
            @(posedge clk);
            @(negedge clk);
        end

        // Round robin with everybody requesting: winners 0..15 then 0.
        do_reset();
        seen.delete();
        for (int i = 0; i < 34; i++) begin
            if (valid_o === 1'b1) seen.push_back(int'(sel_o));
            cyc(16'hFFFF, 64'hFEDC_BA98_7654_3210, 1'b1);
        end
        chk("rr.count", 64'(seen.size()), 64'd17);
        for (int i = 0; i < seen.size(); i++) begin
            chk($sformatf("rr.order%0d", i), 64'(seen[i]), 64'(i % 16));
        end

        // Backpressure on slot 5 while inputs churn.
        do_reset();
        cyc(16'h0020, 64'h0000_0000_0070_0000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(16'($urandom), {$urandom, $urandom}, 1'b0);
        end
        chk("bp.sel", 64'(sel_o), 64'd5);
        chk("bp.data", 64'(data_o), 64'h7);
        cyc(16'($urandom), {$urandom, $urandom}, 1'b1);
        cyc(16'h0000, 64'd0, 1'b1);

        // Wrap-around: serve 14, then 15 and 0 requested.
        do_reset();
        cyc(16'h4000, 64'd0, 1'b1);
        cyc(16'h0000, 64'd0, 1'b1);
        cyc(16'h8001, 64'h5000_0000_0000_0006, 1'b1);
        chk("wrap.first", 64'(sel_o), 64'd15);
        cyc(16'h8001, 64'h5000_0000_0000_0006, 1'b1);
        cyc(16'h8001, 64'h5000_0000_0000_0006, 1'b1);
        chk("wrap.second", 64'(sel_o), 64'd0);
        cyc(16'h0000, 64'd0, 1'b1);

        // Requester 7 drops its request while granted.
        do_reset();
        cyc(16'h0080, 64'h0000_0000_C000_0000, 1'b0);
        cyc(16'h0000, 64'd0, 1'b0);
        cyc(16'h0000, 64'd0, 1'b1);
        cyc(16'h0000, 64'd0, 1'b1);

        // Reset in the middle of SEND: outputs clear at once, no ack.
        do_reset();
        cyc(16'h0004, 64'h0000_0000_0000_0900, 1'b0);
        ready_i = 1'b1;
        rst_n   = 1'b0;
        #1;
        chk("rst.valid", 64'(valid_o), 64'd0);
        chk("rst.sel",   64'(sel_o),   64'd0);
        chk("rst.data",  64'(data_o),  64'd0);
        chk("rst.grant", 64'(grant_o), 64'd0);
        chk("rst.ack",   64'(ack_o),   64'd0);
        @(posedge clk);
        #1;
        chk("rst.ack_edge", 64'(ack_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cyc(16'h0006, 64'h0000_0000_0000_0320, 1'b0);
        chk("rst.winner", 64'(sel_o), 64'd1);
        cyc(16'h0000, 64'd0, 1'b1);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rq = 16'($urandom) & 16'($urandom);
            if ($urandom_range(0, 3) == 0) rq = 16'd0;
            cyc(rq, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mux_rr_arbiter_16.md
MUX_RR_ARBITER_16 -- requirements
Module: mux_rr_arbiter_16

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the data width per requester slot.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-004 The block SHALL have port req_i, input, 16 bits; bit k is the transfer request from requester k.
REQ-005 The block SHALL have port data_i, input, 16*WIDTH bits; requester k's data is at [k*WIDTH +: WIDTH].
REQ-006 The block SHALL have port ready_i, input, 1 bit; the downstream sink accepts data_o when ready_i and valid_o are both 1.
REQ-007 The block SHALL have port data_o, output, WIDTH bits, the registered selected data.
REQ-008 The block SHALL have port valid_o, output, 1 bit; data_o holds a pending transfer.
REQ-009 The block SHALL have port sel_o, output, 4 bits, the index of the current or most recent winner.
REQ-010 The block SHALL have port grant_o, output, 16 bits, one-hot winner while valid_o=1, else all zero.
REQ-011 The block SHALL have port ack_o, output, 16 bits, a one-cycle one-hot pulse to the winner on the handshake cycle.

Function
REQ-012 The FSM SHALL have exactly two states: IDLE (valid_o=0) and SEND (valid_o=1).
REQ-013 In IDLE, when req_i != 0, the block SHALL pick the winner as the first set bit of req_i scanning ptr, ptr+1, ..., ptr+15, wrapping mod 16.
REQ-014 On that edge it SHALL enter SEND, load sel_o=winner and data_o=data_i slot winner, and set grant_o to the winner's one-hot bit.
REQ-015 Latency SHALL be one cycle: a request sampled in IDLE at edge N gives valid_o=1 after edge N.
REQ-016 In IDLE with req_i == 0 the block SHALL hold state, ptr, sel_o and data_o unchanged.
REQ-017 In SEND, data_o, sel_o and grant_o SHALL stay stable until the handshake, whatever req_i or data_i do.
REQ-018 In SEND with ready_i=0 the block SHALL hold all state.
REQ-019 On the SEND cycle with ready_i=1 the block SHALL drive ack_o to the winner's bit combinationally.
REQ-020 On the edge that ends that cycle it SHALL set ptr=(winner+1) mod 16 with 4-bit wrap (winner 15 gives ptr 0), and return to IDLE.
REQ-021 After each handshake there SHALL be exactly one IDLE bubble cycle; the maximum rate is one transfer per two cycles.
REQ-022 A requester that drops req while granted SHALL still have its latched transfer completed and acked.
REQ-023 A winner that keeps req asserted after its ack SHALL get lowest priority in the next arbitration (fairness: each of N active requesters is served within N transfers).
REQ-024 ack_o SHALL be zero in every cycle except a SEND cycle with ready_i=1.

Reset
REQ-025 While rst_n=0, asynchronously and regardless of clk, the block SHALL force state=IDLE, ptr=0, sel_o=0, data_o=0, valid_o=0, grant_o=0 and ack_o=0.
REQ-026 Reset asserted in SEND SHALL abandon the transfer with no ack_o pulse.
REQ-027 After rst_n deasserts, the first arbitration SHALL start from ptr=0.

Verification
REQ-028 Single request: reset, WIDTH=4, req_i=16'h0008, slot3=4'hA, ready_i=1 -> after 1 edge valid_o=1, sel_o=3, data_o=4'hA, grant_o=16'h0008, ack_o=16'h0008 that cycle; next cycle valid_o=0; ptr=4.
REQ-029 Round robin: req_i=16'hFFFF held, ready_i=1 -> winners in order 0,1,2,...,15,0 with valid_o pulsing every other cycle.
REQ-030 Backpressure: grant slot 5 with ready_i=0 for 4 cycles while data_i slot5 and req_i change -> data_o, sel_o=5 and grant_o stable, ack_o=0; ready_i=1 -> single ack_o=16'h0020.
REQ-031 Wrap-around: ptr=15 (after serving 14), req_i=16'h8001 -> winner 15, then winner 0.
REQ-032 Request dropped while granted: slot 7 granted, req_i cleared, then ready_i=1 -> transfer of the latched data completes, ack_o=16'h0080.
REQ-033 Reset mid-SEND: slot 2 granted, ready_i=0, assert rst_n=0 between edges -> all outputs 0 immediately, no ack_o; after release, req_i=16'h0006 -> winner 1.
